// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches words over req/ack, and presents one registered instruction to decode.
// A one-entry skid buffer absorbs a decode stall; a taken branch flushes fetched and in-flight words.
module instr_fetch_unit #(
  parameter int PC_WIDTH                  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int INSTN_WIDTH               = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTN_WIDTH-1:0] imem_rdata,
  output logic [INSTN_WIDTH-1:0] instn,
  output logic                   instn_valid,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [PC_WIDTH-1:0]    pc_plus4
);

  localparam logic [1:0] BOOT    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]             state;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    req_addr;
  logic [INSTN_WIDTH-1:0] instn_q;
  logic [INSTN_WIDTH-1:0] skid_instn;
  logic [PC_WIDTH-1:0]    skid_pc;
  logic                   skid_vld;
  logic [PC_WIDTH-1:0]    req_next;

  assign req_next  = req_addr + PC_WIDTH'(4);
  assign imem_req  = (state == FETCH) || (state == DISCARD);
  assign imem_addr = req_addr;
  // The register keeps the last word; decode only ever sees zero when nothing is live.
  assign instn     = instn_valid ? instn_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      instn_q     <= '0;
      instn_valid <= 1'b0;
      pc_out      <= '0;
      pc_plus4    <= '0;
      skid_instn  <= '0;
      skid_pc     <= '0;
      skid_vld    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          req_addr <= pc;
          state    <= FETCH;
        end

        FETCH: begin
          if (branch_taken) begin
            instn_valid <= 1'b0;
            skid_vld    <= 1'b0;
            pc          <= branch_target;
            // Without an ack the old request must still complete, so its word is discarded later.
            if (imem_ack) req_addr <= branch_target;
            else          state    <= DISCARD;
          end else if (imem_ack) begin
            pc <= req_next;
            if (!instn_valid || !stall) begin
              instn_q     <= imem_rdata;
              pc_out      <= req_addr;
              pc_plus4    <= req_next;
              instn_valid <= 1'b1;
              req_addr    <= req_next;
            end else begin
              skid_instn <= imem_rdata;
              skid_pc    <= req_addr;
              skid_vld   <= 1'b1;
              state      <= HOLD;
            end
          end else if (!stall) begin
            instn_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (branch_taken) begin
            instn_valid <= 1'b0;
            skid_vld    <= 1'b0;
            pc          <= branch_target;
            req_addr    <= branch_target;
            state       <= FETCH;
          end else if (!stall) begin
            if (skid_vld) begin
              instn_q     <= skid_instn;
              pc_out      <= skid_pc;
              pc_plus4    <= skid_pc + PC_WIDTH'(4);
              instn_valid <= 1'b1;
            end
            skid_vld <= 1'b0;
            req_addr <= pc;
            state    <= FETCH;
          end
        end

        default: begin // DISCARD
          if (branch_taken) begin
            instn_valid <= 1'b0;
            skid_vld    <= 1'b0;
            pc          <= branch_target;
          end
          if (imem_ack) begin
            req_addr <= branch_taken ? branch_target : pc;
            state    <= FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory returns addr|0x8C00_0000, ack either tied to req or driven by hand.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instn;
  logic        instn_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;

  logic        auto_ack;
  logic        man_ack;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = imem_addr | 32'h8C00_0000;

  instr_fetch_unit #(
    .PC_WIDTH    (32),
    .RESET_PC    (32'h0000_0000),
    .INSTN_WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instn         (instn),
    .instn_valid   (instn_valid),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    auto_ack = 1'b1; man_ack = 1'b0;
    cyc(); cyc();
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_vld",   {31'd0, instn_valid}, 32'd0);
    chk("rst_instn", instn, 32'd0);
    chk("rst_pc",    pc_out, 32'd0);
    chk("rst_pc4",   pc_plus4, 32'd0);

    // Streaming with zero-wait memory
    rst_n = 1'b1;
    cyc();
    chk("boot_req",  {31'd0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h0);
    chk("boot_vld",  {31'd0, instn_valid}, 32'd0);
    cyc();
    chk("s0_vld",   {31'd0, instn_valid}, 32'd1);
    chk("s0_pc",    pc_out, 32'h0);
    chk("s0_pc4",   pc_plus4, 32'h4);
    chk("s0_instn", instn, 32'h8C00_0000);
    chk("s0_addr",  imem_addr, 32'h4);

    // Three wait states on the fetch of 0x4
    auto_ack = 1'b0; man_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ws_addr",  imem_addr, 32'h4);
      chk("ws_req",   {31'd0, imem_req}, 32'd1);
      chk("ws_vld",   {31'd0, instn_valid}, 32'd0);
      chk("ws_instn", instn, 32'd0);
    end
    man_ack = 1'b1;
    cyc();
    chk("ws_pc",    pc_out, 32'h4);
    chk("ws_instn", instn, 32'h8C00_0004);
    chk("ws_next",  imem_addr, 32'h8);
    cyc();
    chk("s2_pc", pc_out, 32'h8);

    // Stall while 0xC returns: word goes to skid
    stall = 1'b1;
    cyc();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_pc",  pc_out, 32'h8);
    chk("hold_vld", {31'd0, instn_valid}, 32'd1);
    cyc(); // ack stays high while req is low: ignored
    chk("hold2_req", {31'd0, imem_req}, 32'd0);
    chk("hold2_pc",  pc_out, 32'h8);
    stall = 1'b0; man_ack = 1'b0;
    cyc();
    chk("skid_pc",    pc_out, 32'hC);
    chk("skid_pc4",   pc_plus4, 32'h10);
    chk("skid_instn", instn, 32'h8C00_000C);
    chk("skid_addr",  imem_addr, 32'h10);
    chk("skid_req",   {31'd0, imem_req}, 32'd1);

    // Branch while 0x10 is in flight
    branch_taken = 1'b1; branch_target = 32'h40;
    cyc();
    branch_taken = 1'b0;
    chk("bif_vld",  {31'd0, instn_valid}, 32'd0);
    chk("bif_addr", imem_addr, 32'h10);
    chk("bif_req",  {31'd0, imem_req}, 32'd1);
    cyc();
    chk("bif2_addr", imem_addr, 32'h10);
    man_ack = 1'b1;
    cyc();
    chk("disc_vld",  {31'd0, instn_valid}, 32'd0);
    chk("disc_addr", imem_addr, 32'h40);
    cyc();
    chk("tgt_pc",   pc_out, 32'h40);
    chk("tgt_vld",  {31'd0, instn_valid}, 32'd1);
    chk("tgt_addr", imem_addr, 32'h44);

    // Branch coinciding with an ack
    branch_taken = 1'b1; branch_target = 32'h80;
    cyc();
    branch_taken = 1'b0;
    chk("bak_vld",  {31'd0, instn_valid}, 32'd0);
    chk("bak_addr", imem_addr, 32'h80);
    cyc();
    chk("bak_pc", pc_out, 32'h80);

    // Branch during HOLD with stall, to the wrap address
    stall = 1'b1;
    cyc();
    chk("h2_req", {31'd0, imem_req}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    cyc();
    branch_taken = 1'b0;
    chk("bh_vld",  {31'd0, instn_valid}, 32'd0);
    chk("bh_addr", imem_addr, 32'hFFFF_FFFC);
    chk("bh_req",  {31'd0, imem_req}, 32'd1);
    stall = 1'b0;
    cyc();
    chk("wrap_pc",   pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc4",  pc_plus4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset while in DISCARD; the late ack must be ignored
    man_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
    cyc();
    branch_taken = 1'b0;
    chk("d_addr", imem_addr, 32'h0);
    chk("d_req",  {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    cyc();
    chk("rd_req", {31'd0, imem_req}, 32'd0);
    chk("rd_vld", {31'd0, instn_valid}, 32'd0);
    chk("rd_pc",  pc_out, 32'd0);
    rst_n = 1'b1; man_ack = 1'b1;
    cyc();
    chk("rb_req",  {31'd0, imem_req}, 32'd1);
    chk("rb_addr", imem_addr, 32'h0);
    chk("rb_vld",  {31'd0, instn_valid}, 32'd0);
    cyc();
    chk("rr_pc",    pc_out, 32'h0);
    chk("rr_instn", instn, 32'h8C00_0000);
    chk("rr_addr",  imem_addr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
